// File: rtl/mul_div_unit_if.sv
// Handshake/write-back bundle between the core and the iterative RV32M multiply/divide unit.
// The core drives the request side; the unit returns status and the register-file write port.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            wb_enable;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, wb_enable, wb_addr, wb_data
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, wb_enable, wb_addr, wb_data
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: one product/quotient bit per cycle on operand magnitudes,
// with sign fix-up and RISC-V special-case results applied in a final CALC cycle.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);

  localparam int              CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   m_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_q;
  logic              spc_q;
  logic [XLEN-1:0]   wb_data_q;

  // Operand decode at capture
  logic            is_div, a_sgn_op, b_sgn_op, a_neg, b_neg;
  logic            div0, ovf, spc, neg_d;
  logic [XLEN-1:0] a_mag, b_mag, spc_res;

  always_comb begin
    is_div   = bus.funct3[2];
    a_sgn_op = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
               (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_sgn_op = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    a_neg    = a_sgn_op & bus.op_a[XLEN-1];
    b_neg    = b_sgn_op & bus.op_b[XLEN-1];
    a_mag    = a_neg ? -bus.op_a : bus.op_a;
    b_mag    = b_neg ? -bus.op_b : bus.op_b;
    div0     = is_div && (bus.op_b == '0);
    ovf      = is_div && !bus.funct3[0] && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
               (bus.op_b == '1);
    spc      = div0 || ovf;
    // Divide-by-zero: q=all-ones, r=dividend. Overflow: q=dividend (min int), r=0.
    if (div0) spc_res = bus.funct3[1] ? bus.op_a : '1;
    else      spc_res = bus.funct3[1] ? '0 : bus.op_a;
    // Remainder follows the dividend sign; quotient and products follow sign difference.
    neg_d    = (is_div && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // Iteration step and final fix-up
  logic [XLEN:0]     mul_sum, trial, diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res, result;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, m_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    trial    = acc_q[2*XLEN-1:XLEN-1];
    diff     = trial - {1'b0, m_q};
    div_next = diff[XLEN] ? {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    prod     = neg_q ? -acc_q : acc_q;
    mul_res  = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo      = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    if (f3_q[1]) div_res = neg_q ? -rem : rem;
    else         div_res = neg_q ? -quo : quo;
    if (spc_q)        result = acc_q[XLEN-1:0];
    else if (f3_q[2]) result = div_res;
    else              result = mul_res;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.wb_enable = (state_q == S_DONE) && (rd_q != 5'd0);
    bus.wb_addr   = rd_q;
    bus.wb_data   = wb_data_q;
  end

  // Special cases preload the result and skip straight to the fix-up cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      spc_q     <= 1'b0;
      wb_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          f3_q  <= bus.funct3;
          rd_q  <= bus.rd_in;
          neg_q <= neg_d;
          spc_q <= spc;
          cnt_q <= spc ? LAST : '0;
          m_q   <= is_div ? b_mag : a_mag;
          if (spc)         acc_q <= {{XLEN{1'b0}}, spc_res};
          else if (is_div) acc_q <= {{XLEN{1'b0}}, a_mag};
          else             acc_q <= {{XLEN{1'b0}}, b_mag};
        end
        S_CALC: begin
          if (cnt_q != LAST) begin
            acc_q <= f3_q[2] ? div_next : mul_next;
            cnt_q <= cnt_q + 1'b1;
          end else begin
            wb_data_q <= result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed RV32M cases, random operations against an arithmetic
// reference model, latency/hand-shake checks, ignored restarts and mid-operation reset.
module tb_mul_div_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mul_div_unit_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the RV32M definitions using wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    int                 sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    pu  = {32'b0, a} * {32'b0, b};
    case (f3)
      3'd0: return pu[31:0];
      3'd1: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
      3'd2: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    return f3[2] && ((b == 0) ||
           (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Launch one op; glitch>0 re-pulses start that many cycles into the operation.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input int glitch);
    logic [31:0] exp;
    int          lat, ndone, want_lat;
    logic        busy_d, wen_d;
    logic [4:0]  addr_d;
    logic [31:0] data_d;
    exp      = model(f3, a, b);
    want_lat = is_fast(f3, a, b) ? 1 : 33;
    lat = 0; ndone = 0; busy_d = 0; wen_d = 0; addr_d = 0; data_d = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a = $urandom; bus.op_b = $urandom; bus.funct3 = 3'($urandom); bus.rd_in = 5'($urandom);
    for (int k = 1; k <= 40; k++) begin
      bus.start = (k == glitch);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (lat == 0) begin
          lat = k; busy_d = bus.busy; wen_d = bus.wb_enable;
          addr_d = bus.wb_addr; data_d = bus.wb_data;
        end
      end
    end
    chk($sformatf("%s latency", tag), 32'(lat), 32'(want_lat));
    chk($sformatf("%s done_count", tag), 32'(ndone), 32'd1);
    chk($sformatf("%s busy_at_done", tag), {31'b0, busy_d}, 32'd1);
    chk($sformatf("%s wb_enable", tag), {31'b0, wen_d}, {31'b0, rd != 5'd0});
    chk($sformatf("%s wb_addr", tag), {27'b0, addr_d}, {27'b0, rd});
    chk($sformatf("%s wb_data", tag), data_d, exp);
    chk($sformatf("%s wb_data_held", tag), bus.wb_data, exp);
    chk($sformatf("%s idle_after", tag), {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    int nd;
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset done", {31'b0, bus.done}, 32'd0);
    chk("reset wb_enable", {31'b0, bus.wb_enable}, 32'd0);
    chk("reset wb_addr", {27'b0, bus.wb_addr}, 32'd0);
    chk("reset wb_data", bus.wb_data, 32'd0);

    do_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  0);
    do_op("mulhu_ff",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  0);
    do_op("mulh_ff",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  0);
    do_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  0);
    do_op("div_m7_2",  3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  0);
    do_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 0);
    do_op("divu_100",  3'd5, 32'd100,        32'd7,         5'd11, 0);
    do_op("remu_100",  3'd7, 32'd100,        32'd7,         5'd12, 0);
    do_op("divu_by0",  3'd5, 32'h1234,       32'd0,         5'd13, 0);
    do_op("rem_by0",   3'd6, 32'h1234,       32'd0,         5'd14, 0);
    do_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 0);
    do_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 0);
    do_op("mul_rd0",   3'd0, 32'd3,          32'd4,         5'd0,  0);
    do_op("restart",   3'd0, 32'h0001_0003,  32'h0000_0101, 5'd17, 5);

    for (int i = 0; i < 30; i++)
      do_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick(), pick(),
            5'($urandom_range(0, 31)), 0);

    // Reset while computing: abort with no write-back.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.rd_in = 5'd20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort busy", {31'b0, bus.busy}, 32'd0);
    chk("abort done", {31'b0, bus.done}, 32'd0);
    chk("abort wb_data", bus.wb_data, 32'd0);
    chk("abort wb_addr", {27'b0, bus.wb_addr}, 32'd0);
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.wb_enable) nd++;
    end
    chk("abort no_done", 32'(nd), 32'd0);

    do_op("after_abort", 3'd5, 32'd100, 32'd7, 5'd21, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
